// File: rtl/transaction_engine_pkg.sv
// Shared coin-transfer definitions: FSM state codes, balance addresses, default keys
// and the key-to-route decoder used by the transaction engine.
package transaction_engine_pkg;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_SRC  = 4'd1;
  localparam logic [3:0] S_LAT_SRC = 4'd2;
  localparam logic [3:0] S_RD_DST  = 4'd3;
  localparam logic [3:0] S_LAT_DST = 4'd4;
  localparam logic [3:0] S_CHECK   = 4'd5;
  localparam logic [3:0] S_WR_SRC  = 4'd6;
  localparam logic [3:0] S_WR_DST  = 4'd7;
  localparam logic [3:0] S_ANIM    = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  localparam logic P1_ADDR = 1'b0;
  localparam logic P2_ADDR = 1'b1;

  localparam logic [7:0] KEY_P1_DEFAULT = 8'h5A;
  localparam logic [7:0] KEY_P2_DEFAULT = 8'hA5;

  typedef struct packed {
    logic valid;
    logic src;
    logic dst;
  } route_t;

  // Unknown keys still get a well-defined route so the read phase is identical.
  function automatic route_t decode_key(input logic [7:0] key,
                                        input logic [7:0] key_p1,
                                        input logic [7:0] key_p2);
    route_t r;
    r.valid = 1'b1;
    r.src   = P1_ADDR;
    r.dst   = P2_ADDR;
    if (key == key_p1) begin
      r.src = P1_ADDR;
      r.dst = P2_ADDR;
    end else if (key == key_p2) begin
      r.src = P2_ADDR;
      r.dst = P1_ADDR;
    end else begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/transaction_engine_if.sv
// Controller handshake plus balance-memory port of the transaction engine.
interface transaction_engine_if;

  logic       start_transaction;
  logic [7:0] amount;
  logic [7:0] key;
  logic       mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wren;
  logic [7:0] mem_rdata;
  logic       finished_transaction;
  logic       tx_ok;
  logic       tx_rejected;
  logic       anim_active;

  modport master (
    output start_transaction, amount, key, mem_rdata,
    input  mem_addr, mem_wdata, mem_wren, finished_transaction,
           tx_ok, tx_rejected, anim_active
  );

  modport slave (
    input  start_transaction, amount, key, mem_rdata,
    output mem_addr, mem_wdata, mem_wren, finished_transaction,
           tx_ok, tx_rejected, anim_active
  );

endinterface

// File: rtl/transaction_engine_anim_timer.sv
// Animation-phase down-counter: load sets CYCLES-1, done flags the terminal count.
module anim_timer #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int unsigned W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/transaction_engine.sv
// Coin transfer between two player balances: read both, validate, write back, animate.
//
// state   | meaning
// IDLE    | wait for start_transaction, latch amount/key
// RD_SRC  | present source address
// LAT_SRC | capture source balance
// RD_DST  | present destination address
// LAT_DST | capture destination balance
// CHECK   | accept or reject, update tx_ok/tx_rejected
// WR_SRC  | write debited source balance
// WR_DST  | write credited destination balance
// ANIM    | animation phase, ANIM_CYCLES long
// DONE    | finished_transaction until start_transaction drops
module transaction_engine
  import transaction_engine_pkg::*;
#(
  parameter int unsigned ANIM_CYCLES = 50_000_000,
  parameter logic [7:0]  KEY_P1      = KEY_P1_DEFAULT,
  parameter logic [7:0]  KEY_P2      = KEY_P2_DEFAULT
) (
  input logic                 clock,
  input logic                 resetn,
  transaction_engine_if.slave bus
);

  logic [3:0] state_q, state_d;
  logic [7:0] amount_q, amount_d;
  logic       valid_q, valid_d;
  logic       src_q, src_d;
  logic       dst_q, dst_d;
  logic [7:0] src_bal_q, src_bal_d;
  logic [7:0] dst_bal_q, dst_bal_d;
  logic       tx_ok_q, tx_ok_d;
  logic       tx_rej_q, tx_rej_d;

  route_t     route;
  logic [8:0] dst_sum;
  logic       reject;
  logic       timer_load;
  logic       timer_done;

  assign route   = decode_key(bus.key, KEY_P1, KEY_P2);
  assign dst_sum = {1'b0, dst_bal_q} + {1'b0, amount_q};
  assign reject  = !valid_q || (amount_q > src_bal_q) || (dst_sum > 9'd255);

  always_comb begin
    state_d    = state_q;
    amount_d   = amount_q;
    valid_d    = valid_q;
    src_d      = src_q;
    dst_d      = dst_q;
    src_bal_d  = src_bal_q;
    dst_bal_d  = dst_bal_q;
    tx_ok_d    = tx_ok_q;
    tx_rej_d   = tx_rej_q;
    timer_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_transaction) begin
          amount_d = bus.amount;
          valid_d  = route.valid;
          src_d    = route.src;
          dst_d    = route.dst;
          state_d  = S_RD_SRC;
        end
      end
      S_RD_SRC:  state_d = S_LAT_SRC;
      S_LAT_SRC: begin
        src_bal_d = bus.mem_rdata;
        state_d   = S_RD_DST;
      end
      S_RD_DST:  state_d = S_LAT_DST;
      S_LAT_DST: begin
        dst_bal_d = bus.mem_rdata;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        tx_ok_d  = !reject;
        tx_rej_d = reject;
        if (reject) begin
          timer_load = 1'b1;
          state_d    = S_ANIM;
        end else begin
          state_d = S_WR_SRC;
        end
      end
      S_WR_SRC:  state_d = S_WR_DST;
      S_WR_DST: begin
        timer_load = 1'b1;
        state_d    = S_ANIM;
      end
      S_ANIM: begin
        if (timer_done) state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.start_transaction) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      amount_q  <= '0;
      valid_q   <= 1'b0;
      src_q     <= 1'b0;
      dst_q     <= 1'b0;
      src_bal_q <= '0;
      dst_bal_q <= '0;
      tx_ok_q   <= 1'b0;
      tx_rej_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      amount_q  <= amount_d;
      valid_q   <= valid_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      src_bal_q <= src_bal_d;
      dst_bal_q <= dst_bal_d;
      tx_ok_q   <= tx_ok_d;
      tx_rej_q  <= tx_rej_d;
    end
  end

  anim_timer #(.CYCLES(ANIM_CYCLES)) u_anim_timer (
    .clock  (clock),
    .resetn (resetn),
    .load   (timer_load),
    .enable (state_q == S_ANIM),
    .done   (timer_done)
  );

  // Address/data are zero whenever no access is in flight.
  always_comb begin
    bus.mem_addr  = 1'b0;
    bus.mem_wdata = 8'd0;
    bus.mem_wren  = 1'b0;
    case (state_q)
      S_RD_SRC: bus.mem_addr = src_q;
      S_RD_DST: bus.mem_addr = dst_q;
      S_WR_SRC: begin
        bus.mem_addr  = src_q;
        bus.mem_wdata = src_bal_q - amount_q;
        bus.mem_wren  = 1'b1;
      end
      S_WR_DST: begin
        bus.mem_addr  = dst_q;
        bus.mem_wdata = dst_sum[7:0];
        bus.mem_wren  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.finished_transaction = (state_q == S_DONE);
  assign bus.anim_active          = (state_q == S_ANIM);
  assign bus.tx_ok                = tx_ok_q;
  assign bus.tx_rejected          = tx_rej_q;

endmodule

// File: tb/tb_transaction_engine.sv
// Randomized and directed transfers checked cycle-by-cycle against a transaction-level model.
module tb_transaction_engine;

  localparam int N = 4;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  transaction_engine_if bus();

  transaction_engine #(.ANIM_CYCLES(N)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Balance memory with one-cycle read latency.
  logic [7:0] mem [2];
  logic [7:0] rd_q;
  logic       mem_load;
  logic [7:0] load_p1, load_p2;

  always @(posedge clock) begin
    if (mem_load) begin
      mem[0] <= load_p1;
      mem[1] <= load_p2;
    end else if (bus.mem_wren) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    rd_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rd_q;

  int total = 0;
  int bad   = 0;

  // Expected timeline of the current transaction, offsets counted from the latch edge.
  bit         active = 1'b0;
  int         kc;
  bit         e_acc, e_drop;
  logic       e_src, e_dst;
  logic [7:0] e_wsrc, e_wdst;
  int         e_anim_start, e_done_k;
  logic       prev_ok = 1'b0, prev_rej = 1'b0;

  logic [7:0] x_wd;
  logic       x_addr, x_wren, x_anim, x_fin, x_ok, x_rej;

  always @(negedge clock) begin
    if (active) begin
      x_addr = 1'b0; x_wd = 8'd0; x_wren = 1'b0;
      if (kc == 0) x_addr = e_src;
      if (kc == 2) x_addr = e_dst;
      if (e_acc && kc == 5) begin x_addr = e_src; x_wd = e_wsrc; x_wren = 1'b1; end
      if (e_acc && kc == 6) begin x_addr = e_dst; x_wd = e_wdst; x_wren = 1'b1; end
      x_anim = (kc >= e_anim_start) && (kc < e_anim_start + N);
      x_fin  = e_drop ? (kc == e_done_k) : (kc >= e_done_k && kc <= e_done_k + 2);
      x_ok   = (kc >= 5) ? e_acc  : prev_ok;
      x_rej  = (kc >= 5) ? !e_acc : prev_rej;
      total++;
      if ({bus.mem_wren, bus.mem_addr, bus.mem_wdata, bus.anim_active,
           bus.finished_transaction, bus.tx_ok, bus.tx_rejected} !==
          {x_wren, x_addr, x_wd, x_anim, x_fin, x_ok, x_rej}) begin
        bad++;
        $display("FAIL cycle k=%0d got wren=%b addr=%b wdata=%0d anim=%b fin=%b ok=%b rej=%b want wren=%b addr=%b wdata=%0d anim=%b fin=%b ok=%b rej=%b",
                 kc, bus.mem_wren, bus.mem_addr, bus.mem_wdata, bus.anim_active,
                 bus.finished_transaction, bus.tx_ok, bus.tx_rejected,
                 x_wren, x_addr, x_wd, x_anim, x_fin, x_ok, x_rej);
      end
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check_int(name, int'({bus.mem_wren, bus.mem_addr, bus.mem_wdata, bus.anim_active,
                          bus.finished_transaction, bus.tx_ok, bus.tx_rejected}), 0);
  endtask

  task automatic run_txn(input logic [7:0] p1, input logic [7:0] p2,
                         input logic [7:0] k_in, input logic [7:0] amt,
                         input int rst_k, input bit drop_early,
                         input int lit_lat, input int lit_p1, input int lit_p2);
    logic [7:0] b [2];
    logic [7:0] fin_b [2];
    bit valid;
    int first_fin;
    bit aborted;

    b[0] = p1; b[1] = p2;
    valid  = (k_in == 8'h5A) || (k_in == 8'hA5);
    e_src  = (k_in == 8'hA5);
    e_dst  = !e_src;
    e_acc  = valid && (amt <= b[e_src]) && (int'(b[e_dst]) + int'(amt) <= 255);
    e_wsrc = b[e_src] - amt;
    e_wdst = b[e_dst] + amt;
    e_anim_start = e_acc ? 7 : 5;
    e_done_k     = e_anim_start + N;
    e_drop       = drop_early;
    fin_b[0] = b[0]; fin_b[1] = b[1];
    if (e_acc && (rst_k < 0 || rst_k >= 7)) begin
      fin_b[e_src] = e_wsrc;
      fin_b[e_dst] = e_wdst;
    end

    @(negedge clock);
    load_p1 = p1; load_p2 = p2; mem_load = 1'b1;
    @(negedge clock);
    mem_load = 1'b0;
    bus.start_transaction = 1'b1;
    bus.amount = amt;
    bus.key    = k_in;
    @(posedge clock);
    kc = 0; active = 1'b1; first_fin = -1; aborted = 1'b0;
    for (int i = 0; i < e_done_k + 3; i++) begin
      @(negedge clock); #1;
      if (bus.finished_transaction && first_fin < 0) first_fin = kc;
      if (kc == rst_k) begin
        active = 1'b0;
        resetn = 1'b0;
        bus.start_transaction = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset_outputs");
        resetn = 1'b1;
        prev_ok = 1'b0; prev_rej = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (drop_early && kc == 1) bus.start_transaction = 1'b0;
      if (kc == e_done_k + 2) bus.start_transaction = 1'b0;
      @(posedge clock);
      kc++;
    end
    if (!aborted) begin
      @(negedge clock); #1;
      active = 1'b0;
      check_int("latency", first_fin, e_done_k);
      if (lit_lat >= 0) check_int("latency_literal", first_fin, lit_lat);
      prev_ok = e_acc; prev_rej = !e_acc;
    end
    check_int("mem_p1", int'(mem[0]), int'(fin_b[0]));
    check_int("mem_p2", int'(mem[1]), int'(fin_b[1]));
    if (lit_p1 >= 0) check_int("mem_p1_literal", int'(mem[0]), lit_p1);
    if (lit_p2 >= 0) check_int("mem_p2_literal", int'(mem[1]), lit_p2);
  endtask

  initial begin
    logic [7:0] rp1, rp2, rk, ra;
    int sel;
    resetn = 1'b0;
    mem_load = 1'b0; load_p1 = 8'd0; load_p2 = 8'd0;
    bus.start_transaction = 1'b0; bus.amount = 8'd0; bus.key = 8'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outputs_zero("reset_state");
    resetn = 1'b1;

    run_txn(8'd100, 8'd20,  8'h5A, 8'd30,  -1, 1'b0, 11, 70,  50);
    check_int("tx_ok_after_accept", int'(bus.tx_ok), 1);
    run_txn(8'd100, 8'd20,  8'hA5, 8'd21,  -1, 1'b0, 9,  100, 20);
    check_int("tx_rej_after_reject", int'(bus.tx_rejected), 1);
    run_txn(8'd100, 8'd20,  8'h33, 8'd5,   -1, 1'b0, 9,  100, 20);
    run_txn(8'd100, 8'd200, 8'h5A, 8'd60,  -1, 1'b0, 9,  100, 200);
    run_txn(8'd100, 8'd20,  8'h5A, 8'd0,   -1, 1'b0, 11, 100, 20);
    run_txn(8'd100, 8'd155, 8'h5A, 8'd100, -1, 1'b0, 11, 0,   255);
    run_txn(8'd100, 8'd156, 8'h5A, 8'd100, -1, 1'b0, 9,  100, 156);
    run_txn(8'd100, 8'd20,  8'h5A, 8'd30,  3,  1'b0, -1, 100, 20);
    run_txn(8'd100, 8'd20,  8'h5A, 8'd30,  8,  1'b0, -1, 70,  50);
    run_txn(8'd40,  8'd90,  8'hA5, 8'd90,  -1, 1'b1, 11, 130, 0);

    for (int t = 0; t < 30; t++) begin
      rp1 = 8'($urandom_range(0, 255));
      rp2 = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 3);
      rk  = (sel < 2) ? 8'h5A : (sel == 2) ? 8'hA5 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) ra = (rk == 8'hA5) ? rp2 : rp1;
      else ra = 8'($urandom_range(0, 255));
      run_txn(rp1, rp2, rk, ra, -1, 1'b0, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
